// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants and types for the decode stage.
//   - instruction codes IHALT..IPOPQ
//   - register IDs RNONE (no register) and RRSP (stack pointer)
//   - status codes SAOK, SADR, SINS, SHLT
//   - e_reg_t, the E pipeline register layout, and E_BUBBLE, its bubble value
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SADR = 4'h2;
    localparam logic [3:0] SINS = 4'h3;
    localparam logic [3:0] SHLT = 4'h4;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        valC:  64'd0,
        valA:  64'd0,
        valB:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 15 x 64-bit Y86-64 register file.
//   clk, rst          clock and asynchronous active-high clear (all entries to 0)
//   i_srcA, i_srcB    read addresses; RNONE reads as 0
//   o_valA, o_valB    combinational read data (no write-through bypass)
//   i_dstE, i_valE    write port E, ignored when i_dstE is RNONE
//   i_dstM, i_valM    write port M, ignored when i_dstM is RNONE; wins over E
module regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_srcA,
    input  logic [3:0]  i_srcB,
    output logic [63:0] o_valA,
    output logic [63:0] o_valB,
    input  logic [3:0]  i_dstE,
    input  logic [63:0] i_valE,
    input  logic [3:0]  i_dstM,
    input  logic [63:0] i_valM
);

    logic [63:0] r_regs [0:14];

    for (genvar g = 0; g < 15; g++) begin : g_entry
        // Per-entry write: port M is checked first so it wins a shared destination.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_regs[g] <= 64'd0;
            end else if (i_dstM == 4'(g)) begin
                r_regs[g] <= i_valM;
            end else if (i_dstE == 4'(g)) begin
                r_regs[g] <= i_valE;
            end else begin
                r_regs[g] <= r_regs[g];
            end
        end
    end

    // Read port A; RNONE has no backing entry and reads as 0.
    always_comb begin
        o_valA = 64'd0;
        if (i_srcA != RNONE) begin
            o_valA = r_regs[i_srcA];
        end else begin
            o_valA = 64'd0;
        end
    end

    // Read port B; RNONE has no backing entry and reads as 0.
    always_comb begin
        o_valB = 64'd0;
        if (i_srcB != RNONE) begin
            o_valB = r_regs[i_srcB];
        end else begin
            o_valB = 64'd0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode / write-back stage.
//   clk, rst                  clock, asynchronous active-high reset
//   D_*                       D pipeline register from fetch
//   E_bubble                  load a bubble into E this cycle
//   e_*, M_*, m_valM, W_*     forwarding sources; W_* also drive regfile writes
//   d_srcA, d_srcB            combinational source IDs for the control unit
//   E_*                       E pipeline register to execute
// Build option DECODE_FWD_EN: when defined, the full E/M/W forwarding chain is
// active; when undefined, operands come straight from the register file (the
// control unit stalls instead) and the forwarding inputs are ignored.
module decode_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);

`ifdef DECODE_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic [3:0]  w_srcA;
    logic [3:0]  w_srcB;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic [63:0] w_rf_valA;
    logic [63:0] w_rf_valB;
    logic [63:0] w_valA;
    logic [63:0] w_valB;
    e_reg_t      r_e;

    // Forwarding priority: newest producer first; RNONE never matches.
    function automatic logic [63:0] fwd_pick(
        input logic [3:0]  src,
        input logic [63:0] rf_val,
        input logic [3:0]  e_dst,  input logic [63:0] e_val,
        input logic [3:0]  mm_dst, input logic [63:0] mm_val,
        input logic [3:0]  me_dst, input logic [63:0] me_val,
        input logic [3:0]  wm_dst, input logic [63:0] wm_val,
        input logic [3:0]  we_dst, input logic [63:0] we_val
    );
        logic [63:0] v;
        if (!FWD_EN || src == RNONE) v = rf_val;
        else if (src == e_dst)       v = e_val;
        else if (src == mm_dst)      v = mm_val;
        else if (src == me_dst)      v = me_val;
        else if (src == wm_dst)      v = wm_val;
        else if (src == we_dst)      v = we_val;
        else                         v = rf_val;
        return v;
    endfunction

    // Source and destination register IDs selected by instruction class.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            IRRMOVQ: begin w_srcA = D_rA; w_dstE = D_rB; end
            IIRMOVQ: begin w_dstE = D_rB; end
            IRMMOVQ: begin w_srcA = D_rA; w_srcB = D_rB; end
            IMRMOVQ: begin w_srcB = D_rB; w_dstM = D_rA; end
            IOPQ:    begin w_srcA = D_rA; w_srcB = D_rB; w_dstE = D_rB; end
            ICALL:   begin w_srcB = RRSP; w_dstE = RRSP; end
            IRET:    begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; end
            IPUSHQ:  begin w_srcA = D_rA; w_srcB = RRSP; w_dstE = RRSP; end
            IPOPQ:   begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; w_dstM = D_rA; end
            default: begin w_srcA = RNONE; w_srcB = RNONE; w_dstE = RNONE; w_dstM = RNONE; end
        endcase
    end

    assign d_srcA = w_srcA;
    assign d_srcB = w_srcB;

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .i_srcA (w_srcA),
        .i_srcB (w_srcB),
        .o_valA (w_rf_valA),
        .o_valB (w_rf_valB),
        .i_dstE (W_dstE),
        .i_valE (W_valE),
        .i_dstM (W_dstM),
        .i_valM (W_valM)
    );

    // Operand A: call/jXX carry the return/fall-through PC instead of a register.
    always_comb begin
        w_valA = 64'd0;
        if (D_icode == ICALL || D_icode == IJXX) begin
            w_valA = D_valP;
        end else begin
            w_valA = fwd_pick(w_srcA, w_rf_valA, e_dstE, e_valE, M_dstM, m_valM,
                              M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        end
    end

    // Operand B: same forwarding chain without the PC override.
    always_comb begin
        w_valB = fwd_pick(w_srcB, w_rf_valB, e_dstE, e_valE, M_dstM, m_valM,
                          M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    // E pipeline register; a bubble discards everything decoded this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= E_BUBBLE;
        end else if (E_bubble) begin
            r_e <= E_BUBBLE;
        end else begin
            r_e <= '{stat: D_stat, icode: D_icode, ifun: D_ifun, valC: D_valC,
                     valA: w_valA, valB: w_valB, dstE: w_dstE, dstM: w_dstM,
                     srcA: w_srcA, srcB: w_srcB};
        end
    end

    assign E_stat  = r_e.stat;
    assign E_icode = r_e.icode;
    assign E_ifun  = r_e.ifun;
    assign E_valC  = r_e.valC;
    assign E_valA  = r_e.valA;
    assign E_valB  = r_e.valB;
    assign E_dstE  = r_e.dstE;
    assign E_dstM  = r_e.dstM;
    assign E_srcA  = r_e.srcA;
    assign E_srcB  = r_e.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// Expected operand values depend on DECODE_FWD_EN, matching the RTL build.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    int n_checks;
    int n_errors;

`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    decode_stage dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        D_stat  = 4'h1;
        D_icode = icode;
        D_ifun  = 4'h0;
        D_rA    = ra;
        D_rB    = rb;
    endtask

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    // icode -> expected {srcA, srcB} with rA=1, rB=2
    logic [3:0] tbl_icode [0:10] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [3:0] tbl_srcA  [0:10] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'hF, 4'h1, 4'hF, 4'hF, 4'h4, 4'h1, 4'h4};
    logic [3:0] tbl_srcB  [0:10] = '{4'hF, 4'hF, 4'hF, 4'h2, 4'h2, 4'h2, 4'hF, 4'h4, 4'h4, 4'h4, 4'h4};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        E_bubble = 1'b0;
        D_valC = 64'd0;
        D_valP = 64'd0;
        set_d(4'h1, 4'hF, 4'hF);
        clear_fwd();
        #12;
        check_eq("rst_E_icode", {60'd0, E_icode}, 64'h1);
        check_eq("rst_E_stat",  {60'd0, E_stat},  64'h1);
        check_eq("rst_E_dstE",  {60'd0, E_dstE},  64'hF);
        check_eq("rst_E_valA",  E_valA,           64'h0);
        rst = 1'b0;

        // Register file reads 0 after reset.
        set_d(4'h6, 4'h7, 4'hE);
        tick();
        check_eq("rst_rf_r7",  E_valA, 64'h0);
        check_eq("rst_rf_r14", E_valB, 64'h0);

        // Source ID decode table.
        for (int i = 0; i < 11; i++) begin
            set_d(tbl_icode[i], 4'h1, 4'h2);
            #1;
            check_eq($sformatf("srcA_i%0h", tbl_icode[i]), {60'd0, d_srcA}, {60'd0, tbl_srcA[i]});
            check_eq($sformatf("srcB_i%0h", tbl_icode[i]), {60'd0, d_srcB}, {60'd0, tbl_srcB[i]});
        end

        // Write r3=100 through port E, read next cycle.
        set_d(4'h1, 4'hF, 4'hF);
        W_dstE = 4'h3; W_valE = 64'd100;
        tick();
        clear_fwd();
        set_d(4'h6, 4'h3, 4'h3);
        tick();
        check_eq("wb_r3_valA", E_valA, 64'd100);
        check_eq("wb_r3_valB", E_valB, 64'd100);
        check_eq("opq_icode",  {60'd0, E_icode}, 64'h6);
        check_eq("opq_dstE",   {60'd0, E_dstE},  64'h3);
        check_eq("opq_dstM",   {60'd0, E_dstM},  64'hF);

        // Forwarding priority on rA=2; r2 preloaded with 55.
        set_d(4'h1, 4'hF, 4'hF);
        W_dstE = 4'h2; W_valE = 64'd55;
        tick();
        set_d(4'h6, 4'h2, 4'hF);
        e_dstE = 4'h2; e_valE = 64'd7;
        M_dstE = 4'h2; M_valE = 64'd8;
        W_dstE = 4'h2; W_valE = 64'd9;
        tick();
        check_eq("fwd_e_wins", E_valA, FWD ? 64'd7 : 64'd55);
        e_dstE = 4'hF;
        tick();
        check_eq("fwd_M_valE", E_valA, FWD ? 64'd8 : 64'd9);
        M_dstM = 4'h2; m_valM = 64'd11;
        tick();
        check_eq("fwd_m_valM", E_valA, FWD ? 64'd11 : 64'd9);
        M_dstM = 4'hF; M_dstE = 4'hF;
        W_dstM = 4'h2; W_valM = 64'd12;
        tick();
        check_eq("fwd_W_valM", E_valA, FWD ? 64'd12 : 64'd9);
        clear_fwd();

        // call: valA carries valP, stack pointer as srcB/dstE.
        set_d(4'h8, 4'hF, 4'hF);
        D_valP = 64'h40; D_valC = 64'h1234;
        tick();
        check_eq("call_valA", E_valA, 64'h40);
        check_eq("call_valC", E_valC, 64'h1234);
        check_eq("call_srcA", {60'd0, E_srcA}, 64'hF);
        check_eq("call_srcB", {60'd0, E_srcB}, 64'h4);
        check_eq("call_dstE", {60'd0, E_dstE}, 64'h4);
        check_eq("call_dstM", {60'd0, E_dstM}, 64'hF);

        // Same-destination write: port M wins.
        set_d(4'h1, 4'hF, 4'hF);
        W_dstE = 4'h5; W_valE = 64'd1;
        W_dstM = 4'h5; W_valM = 64'd2;
        tick();
        clear_fwd();
        set_d(4'h6, 4'h5, 4'h3);
        tick();
        check_eq("wb_M_wins", E_valA, 64'd2);

        // popq rA=6.
        set_d(4'hB, 4'h6, 4'hF);
        tick();
        check_eq("pop_srcA", {60'd0, E_srcA}, 64'h4);
        check_eq("pop_dstM", {60'd0, E_dstM}, 64'h6);
        check_eq("pop_dstE", {60'd0, E_dstE}, 64'h4);

        // Bubble beats a valid OPq with a forwarding match.
        set_d(4'h6, 4'h5, 4'h3);
        e_dstE = 4'h5; e_valE = 64'd77;
        E_bubble = 1'b1;
        tick();
        check_eq("bub_icode", {60'd0, E_icode}, 64'h1);
        check_eq("bub_dstE",  {60'd0, E_dstE},  64'hF);
        check_eq("bub_valA",  E_valA,           64'h0);
        E_bubble = 1'b0;
        clear_fwd();

        // Mid-cycle async reset clears E and the register file.
        tick();
        check_eq("pre_rst_icode", {60'd0, E_icode}, 64'h6);
        #2 rst = 1'b1;
        #1;
        check_eq("async_icode", {60'd0, E_icode}, 64'h1);
        check_eq("async_dstE",  {60'd0, E_dstE},  64'hF);
        #1 rst = 1'b0;
        tick();
        check_eq("post_rst_r5", E_valA, 64'h0);
        check_eq("post_rst_r3", E_valB, 64'h0);
        check_eq("post_rst_icode", {60'd0, E_icode}, 64'h6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
